// File: rtl/ram_dp_core.sv
// Dual-port RAM core: one write port, one registered read port, hardware clear after reset.
// Optional per-word even parity with error injection when RAM_PARITY_EN is defined.
module ram_dp_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_enb,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_enb,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
`ifdef RAM_PARITY_EN
  input  logic                  par_inject,
  output logic                  par_err,
`endif
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  addr_err,
  output logic                  init_busy
);

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_IDLE = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  addr_err_q, addr_err_d;
  logic                  init_busy_q, init_busy_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  wr_ok;
  logic                  rd_ok;

`ifdef RAM_PARITY_EN
  logic par_mem [DEPTH];
  logic mem_wpar;
  logic par_err_q, par_err_d;
`endif

  // Range checks collapse to constant-true when the address space matches DEPTH
  if (DEPTH >= 2 ** ADDR_WIDTH) begin : g_full_range
    assign wr_ok = 1'b1;
    assign rd_ok = 1'b1;
  end else begin : g_part_range
    assign wr_ok = (wr_addr < ADDR_WIDTH'(DEPTH));
    assign rd_ok = (rd_addr < ADDR_WIDTH'(DEPTH));
  end

  // Next-state, memory write port and registered-output next values
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    init_busy_d = init_busy_q;
    data_out_d  = data_out_q;
    rd_valid_d  = 1'b0;
    addr_err_d  = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = wr_addr;
    mem_wdata   = data_in;
`ifdef RAM_PARITY_EN
    mem_wpar    = (^data_in) ^ par_inject;
    par_err_d   = 1'b0;
`endif
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
`ifdef RAM_PARITY_EN
        mem_wpar  = 1'b0;
`endif
        ptr_d     = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == LAST_PTR) begin
          state_d     = ST_IDLE;
          init_busy_d = 1'b0;
          ptr_d       = '0;
        end
      end
      ST_IDLE: begin
        if (wr_enb) begin
          if (wr_ok) begin
            mem_we = 1'b1;
          end else begin
            addr_err_d = 1'b1;
          end
        end
        if (rd_enb) begin
          rd_valid_d = 1'b1;
          if (!rd_ok) begin
            data_out_d = '0;
            addr_err_d = 1'b1;
          end else if (wr_enb && wr_ok && (wr_addr == rd_addr)) begin
            // Write-first bypass: new data is returned, parity is not checked
            data_out_d = data_in;
          end else begin
            data_out_d = mem[rd_addr];
`ifdef RAM_PARITY_EN
            par_err_d  = (^mem[rd_addr]) != par_mem[rd_addr];
`endif
          end
        end
      end
      default: begin
        state_d     = ST_INIT;
        init_busy_d = 1'b1;
        ptr_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      ptr_q       <= '0;
      init_busy_q <= 1'b1;
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      addr_err_q  <= 1'b0;
`ifdef RAM_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_busy_q <= init_busy_d;
      data_out_q  <= data_out_d;
      rd_valid_q  <= rd_valid_d;
      addr_err_q  <= addr_err_d;
`ifdef RAM_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  // Storage array is deliberately not reset; the clear sequence zeroes it
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
`ifdef RAM_PARITY_EN
      par_mem[mem_waddr] <= mem_wpar;
`endif
    end
  end

  assign data_out  = data_out_q;
  assign rd_valid  = rd_valid_q;
  assign addr_err  = addr_err_q;
  assign init_busy = init_busy_q;
`ifdef RAM_PARITY_EN
  assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_ram_dp_core.sv
// Bench for ram_dp_core: a DEPTH=16 and a DEPTH=12 instance share one stimulus stream,
// each checked against its own reference model through an expected-result queue.
module tb_ram_dp_core;

  typedef struct packed {
    logic       vld;
    logic       err;
    logic       perr;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       wr_enb;
  logic [3:0] wr_addr;
  logic [7:0] data_in;
  logic       rd_enb;
  logic [3:0] rd_addr;

  logic [7:0] dout0, dout1;
  logic       vld0, vld1, aerr0, aerr1, busy0, busy1;
`ifdef RAM_PARITY_EN
  logic       par_inject;
  logic       perr0, perr1;
`endif

  int checks = 0;
  int errors = 0;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] m_mem  [2][16];
  logic       m_bad  [2][16];
  logic [7:0] m_last [2];
  int         busy_cnt [2];
  int         depth_of [2];

  ram_dp_core #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .wr_enb(wr_enb), .wr_addr(wr_addr), .data_in(data_in),
    .rd_enb(rd_enb), .rd_addr(rd_addr),
`ifdef RAM_PARITY_EN
    .par_inject(par_inject), .par_err(perr0),
`endif
    .data_out(dout0), .rd_valid(vld0), .addr_err(aerr0), .init_busy(busy0)
  );

  ram_dp_core #(.DATA_WIDTH(8), .DEPTH(12), .ADDR_WIDTH(4)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .wr_enb(wr_enb), .wr_addr(wr_addr), .data_in(data_in),
    .rd_enb(rd_enb), .rd_addr(rd_addr),
`ifdef RAM_PARITY_EN
    .par_inject(par_inject), .par_err(perr1),
`endif
    .data_out(dout1), .rd_valid(vld1), .addr_err(aerr1), .init_busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Reference behaviour for one instance given the inputs about to be sampled
  task automatic model(input int k, input logic inj, output exp_t e);
    int   d;
    logic wok, rok;
    d      = depth_of[k];
    e.vld  = 1'b0;
    e.err  = 1'b0;
    e.perr = 1'b0;
    e.data = m_last[k];
    if (busy_cnt[k] == 0) begin
      wok = (int'(wr_addr) < d);
      rok = (int'(rd_addr) < d);
      if (rd_enb) begin
        e.vld = 1'b1;
        if (!rok) e.data = 8'h00;
        else if (wr_enb && wok && (wr_addr == rd_addr)) e.data = data_in;
        else begin
          e.data = m_mem[k][rd_addr];
          e.perr = m_bad[k][rd_addr];
        end
      end
      e.err = (wr_enb && !wok) || (rd_enb && !rok);
      if (wr_enb && wok) begin
        m_mem[k][wr_addr] = data_in;
        m_bad[k][wr_addr] = inj;
      end
      m_last[k] = e.data;
    end else begin
      busy_cnt[k]--;
    end
  endtask

  task automatic compare(input int k);
    exp_t e;
    logic [7:0] d;
    logic v, a;
    if ((k == 0 ? q0.size() : q1.size()) == 0) begin
      errors++;
      $error("FAIL d%0d_scoreboard observed=empty expected=entry", k);
      return;
    end
    e = (k == 0) ? q0.pop_front() : q1.pop_front();
    d = (k == 0) ? dout0 : dout1;
    v = (k == 0) ? vld0  : vld1;
    a = (k == 0) ? aerr0 : aerr1;
    chk($sformatf("d%0d_rd_valid", k), 32'(v), 32'(e.vld));
    chk($sformatf("d%0d_data_out", k), 32'(d), 32'(e.data));
    chk($sformatf("d%0d_addr_err", k), 32'(a), 32'(e.err));
`ifdef RAM_PARITY_EN
    chk($sformatf("d%0d_par_err", k), 32'((k == 0) ? perr0 : perr1), 32'(e.perr));
`endif
  endtask

  // One clock of stimulus: drive, predict, clock, compare
  task automatic step(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                      input logic re, input logic [3:0] ra, input logic inj);
    exp_t e0, e1;
    wr_enb  = we;
    wr_addr = wa;
    data_in = wd;
    rd_enb  = re;
    rd_addr = ra;
`ifdef RAM_PARITY_EN
    par_inject = inj;
`endif
    model(0, inj, e0);
    q0.push_back(e0);
    model(1, inj, e1);
    q1.push_back(e1);
    @(posedge clk);
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic chk_busy();
    chk("d0_init_busy", 32'(busy0), 32'(busy_cnt[0] > 0));
    chk("d1_init_busy", 32'(busy1), 32'(busy_cnt[1] > 0));
  endtask

  // Assert reset, check immediate output state, release and run the clear window
  task automatic do_reset(input logic traffic);
    rst_n  = 1'b0;
    wr_enb = 1'b0;
    rd_enb = 1'b0;
    #1;
    chk("rst_d0_rd_valid", 32'(vld0), 32'd0);
    chk("rst_d1_rd_valid", 32'(vld1), 32'd0);
    chk("rst_d0_data_out", 32'(dout0), 32'd0);
    chk("rst_d0_addr_err", 32'(aerr0), 32'd0);
    chk("rst_d0_init_busy", 32'(busy0), 32'd1);
    chk("rst_d1_init_busy", 32'(busy1), 32'd1);
    for (int k = 0; k < 2; k++) begin
      busy_cnt[k] = depth_of[k];
      m_last[k]   = 8'h00;
      for (int a = 0; a < 16; a++) begin
        m_mem[k][a] = 8'h00;
        m_bad[k][a] = 1'b0;
      end
    end
    q0.delete();
    q1.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk_busy();
      if (traffic) step(1'b1, 4'd3, 8'hFF, 1'b1, 4'd3, 1'b0);
      else         step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
    end
    chk_busy();
  endtask

  initial begin
    depth_of[0] = 16;
    depth_of[1] = 12;
    rst_n   = 1'b1;
    wr_enb  = 1'b0;
    wr_addr = 4'd0;
    data_in = 8'h00;
    rd_enb  = 1'b0;
    rd_addr = 4'd0;
`ifdef RAM_PARITY_EN
    par_inject = 1'b0;
`endif
    #3;
    do_reset(1'b0);
    chk("clear_done_d0", 32'(busy0), 32'd0);

    // Every location reads back zero after the clear
    for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 8'h00, 1'b1, 4'(a), 1'b0);
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);

    // Basic write then back-to-back reads
    step(1'b1, 4'd3,  8'hA5, 1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd15, 8'h5A, 1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0,  8'h00, 1'b1, 4'd3, 1'b0);
    chk("basic_rd3_d0", 32'(dout0), 32'hA5);
    step(1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 1'b0);
    chk("basic_rd15_d0", 32'(dout0), 32'h5A);
    chk("basic_rd15_valid_d0", 32'(vld0), 32'd1);
    step(1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 1'b0);

    // Same-address read during write returns the new data
    step(1'b1, 4'd7, 8'h11, 1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd7, 8'h3C, 1'b1, 4'd7, 1'b0);
    chk("collide_d0", 32'(dout0), 32'h3C);
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 1'b0);
    chk("collide_after_d0", 32'(dout0), 32'h3C);
    step(1'b1, 4'd5, 8'h99, 1'b1, 4'd3, 1'b0);

    // Out-of-range on the 12-deep instance
    step(1'b1, 4'd13, 8'h77, 1'b0, 4'd0, 1'b0);
    chk("oor_wr_err_d1", 32'(aerr1), 32'd1);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd13, 1'b0);
    chk("oor_rd_err_d1", 32'(aerr1), 32'd1);
    chk("oor_rd_data_d1", 32'(dout1), 32'h00);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd11, 1'b0);
    chk("oor_addr11_d1", 32'(dout1), 32'h00);
    step(1'b1, 4'd14, 8'h42, 1'b1, 4'd12, 1'b0);
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);

`ifdef RAM_PARITY_EN
    step(1'b1, 4'd2, 8'hF0, 1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b0);
    chk("par_inject_d0", 32'(perr0), 32'd1);
    step(1'b1, 4'd2, 8'hF0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b0);
    chk("par_clean_d0", 32'(perr0), 32'd0);
    step(1'b1, 4'd4, 8'h01, 1'b1, 4'd4, 1'b1);
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
`endif

    // Reset in the middle of a read of address 3
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b0);
    chk("pre_reset_valid_d0", 32'(vld0), 32'd1);
    do_reset(1'b1);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b0);
    chk("post_clear_rd3_d0", 32'(dout0), 32'h00);
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_dp_core.md
Name: ram_dp_core

Overview:
- Synchronous dual-port RAM core: one write port, one read port, registered read data.
- This is the DUT that the read agent (driver/monitor) and the write agent stimulate and observe.
- After every reset it runs a hardware clear sequence that zeroes all locations.
- It also flags out-of-range accesses and handles same-cycle read/write to the same address deterministically.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 16, number of locations; need not be a power of 2.
- ADDR_WIDTH, 4, address bus width; must satisfy 2**ADDR_WIDTH >= DEPTH.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_enb  input  1  write request, sampled on clk.
- wr_addr  input  ADDR_WIDTH  write address.
- data_in  input  DATA_WIDTH  write data.
- rd_enb  input  1  read request, sampled on clk.
- rd_addr  input  ADDR_WIDTH  read address.
- data_out  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  one-cycle pulse, data_out valid.
- addr_err  output  1  one-cycle pulse, previous-cycle access was out of range.
- init_busy  output  1  clear sequence in progress; all requests ignored.

Behaviour:
- Reset: asynchronous assertion on rst_n low, synchronous release. While rst_n is low:
  - data_out=0, rd_valid=0, addr_err=0.
  - init_busy=1, FSM=INIT, clear pointer=0.
  - Memory array itself is not reset asynchronously.
- FSM states INIT and IDLE:
  - INIT: each cycle write 0 to mem[ptr], ptr++. When ptr==DEPTH-1 is written, go to IDLE next cycle; init_busy drops in that same transition.
  - Clear takes exactly DEPTH cycles after rst_n rises.
  - IDLE: normal operation. It leaves IDLE only on reset.
- Reset mid-operation (any state): return to INIT immediately, restart from ptr=0, drop any in-flight read (rd_valid=0).
- Requests while init_busy=1: wr_enb and rd_enb are ignored entirely. No write, no rd_valid, no addr_err.
- Write, when wr_enb=1 in IDLE:
  - wr_addr<DEPTH: mem[wr_addr]<=data_in at that edge.
  - wr_addr>=DEPTH: write dropped, addr_err=1 next cycle.
- Read latency is 1 cycle. rd_enb=1 in IDLE at edge N gives rd_valid=1 and data_out=mem[rd_addr] after edge N.
  - rd_valid deasserts the following cycle unless another read is issued.
  - data_out holds its last value when rd_valid=0.
  - Back-to-back reads every cycle are allowed; rd_valid stays high.
- Out-of-range read (rd_addr>=DEPTH): rd_valid=1, data_out=0, addr_err=1, all in the same cycle.
- Read-during-write to the same in-range address at the same edge: write-first. data_out=data_in (new data).
  - Different addresses are independent.
- addr_err: single pulse, OR of write and read out-of-range in the previous cycle.

Optional Feature:
- Macro: RAM_PARITY_EN.
- When defined:
  - Each location stores one extra even-parity bit computed from data_in on write.
  - INIT writes parity 0.
  - On read, recomputed parity is compared with stored parity. Output port par_err (1 bit) pulses with rd_valid on mismatch.
  - Bypassed (write-first) reads never flag.
  - Input port par_inject (1 bit): when high with wr_enb, the stored parity bit is inverted.
- When undefined: no extra storage, and neither par_err nor par_inject exists.

Test Plan:
- Clear: release rst_n, poll init_busy -> init_busy high exactly 16 cycles. Then read addrs 0..15 -> data_out=0x00 each, rd_valid one cycle after each rd_enb.
- Basic write/read: write 0xA5 to addr 3 and 0x5A to addr 15, then read 3 and 15 back-to-back -> data_out 0xA5 then 0x5A on consecutive cycles, rd_valid high 2 cycles.
- Collision: data at addr 7 is 0x11; same edge wr_enb=1 (addr 7, 0x3C) and rd_enb=1 (addr 7) -> data_out=0x3C. Next read of addr 7 -> 0x3C.
- Out of range: with DEPTH=12, write addr 13 then read addr 13 -> write dropped, addr_err pulses each cycle; read gives rd_valid=1, data_out=0x00. Addr 11 is unaffected.
- Reset mid-operation: assert rst_n low during a read of addr 3 (holding 0xA5) -> rd_valid=0 immediately, init_busy=1. Requests during the 16 clear cycles are ignored. A post-clear read of addr 3 -> 0x00.
- RAM_PARITY_EN: write 0xF0 to addr 2 with par_inject=1, then read addr 2 -> par_err=1 with data_out=0xF0. Rewrite 0xF0 without inject, then read -> par_err=0.
